int2float_pipe: RTL

- Parametrised, pipelined integer-to-minifloat converter. Successor to the team's fixed 11-bit-in / 7-bit-out combinational converter.
- Adds generic widths, signed/unsigned input, a valid/ready handshake with backpressure, saturation flagging and a saturation event counter.
- Sits between integer datapath producers and compact float consumers.
- Format: value = man << exp. The mantissa is the MAN_W bits starting at the leading one, with the leading one stored explicitly. No bias.

---
 rtl/int2float_pkg.sv | 34 +++
 rtl/int2float_lod.sv | 24 ++
 rtl/int2float_pipe.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/int2float_pkg.sv
// rtl/int2float_pkg.sv - shared types, widths and saturation helpers for the int-to-minifloat pipe
package int2float_pkg;

    // Default format: 11-bit integer in, 3-bit exponent, 4-bit explicit-one mantissa
    localparam int DEF_IN_W  = 11;
    localparam int DEF_EXP_W = 3;
    localparam int DEF_MAN_W = 4;

    // Packed result in the default format (value = man << exp, no bias)
    typedef struct packed {
        logic                 sign;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_MAN_W-1:0] man;
    } fp_t;

    // Width of a leading-one index for a w-bit operand
    function automatic int lod_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Largest encodable exponent for an ew-bit field
    function automatic int exp_max(input int ew);
        return (1 << ew) - 1;
    endfunction

    // All-ones mantissa used when the result saturates
    function automatic int man_max(input int mw);
        return (1 << mw) - 1;
    endfunction

    localparam int EXP_MAX = exp_max(DEF_EXP_W);
    localparam int MAN_MAX = man_max(DEF_MAN_W);

endpackage

// File: rtl/int2float_lod.sv
// rtl/int2float_lod.sv - combinational leading-one detector with zero flag
module int2float_lod
    import int2float_pkg::*;
#(
    parameter int IN_W = DEF_IN_W,
    parameter int LW   = lod_w(IN_W)
) (
    input  logic [IN_W-1:0] data_i,
    output logic [LW-1:0]   idx_o,
    output logic            zero_o
);

    // Scan upward so the highest set bit wins; index is 0 when the operand is zero
    always_comb begin
        idx_o  = '0;
        zero_o = ~|data_i;
        for (int i = 0; i < IN_W; i++) begin
            if (data_i[i]) begin
                idx_o = LW'(i);
            end
        end
    end

endmodule

// File: rtl/int2float_pipe.sv
// rtl/int2float_pipe.sv - two-stage integer to minifloat converter; INT2FLOAT_RNE_EN enables round-to-nearest-even
module int2float_pipe
    import int2float_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int EXP_W  = DEF_EXP_W,
    parameter int MAN_W  = DEF_MAN_W,
    parameter int SIGNED = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_man,
    output logic             out_sat,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             sat_clr
);

    localparam int LW   = lod_w(IN_W);
    localparam int EMAX = exp_max(EXP_W);

    logic             s1_advance;
    logic             s2_advance;

    logic             s1_sign_d;
    logic [IN_W-1:0]  s1_mag_d;
    logic [LW-1:0]    s1_p_d;
    logic             s1_zero_d;

    logic             s1_valid_q;
    logic             s1_sign_q;
    logic [IN_W-1:0]  s1_mag_q;
    logic [LW-1:0]    s1_p_q;
    logic             s1_zero_q;

    int               exp_int;
    logic [MAN_W-1:0] man_w;
`ifdef INT2FLOAT_RNE_EN
    logic             guard;
    logic             sticky;
    logic [MAN_W:0]   man_r;
`endif

    logic             sign_d;
    logic [EXP_W-1:0] exp_d;
    logic [MAN_W-1:0] man_d;
    logic             sat_d;

    logic             s2_valid_q;
    logic             sign_q;
    logic [EXP_W-1:0] exp_q;
    logic [MAN_W-1:0] man_q;
    logic             sat_q;
    logic [CNT_W-1:0] sat_cnt_q;

    // S2 moves when its slot is empty or being drained; S1 moves behind it or when empty
    assign s2_advance = !s2_valid_q || out_ready;
    assign s1_advance = s2_advance || !s1_valid_q;
    assign in_ready   = s1_advance;

    // Split the operand into sign and unsigned magnitude (most-negative value fits in IN_W bits)
    always_comb begin
        s1_sign_d = (SIGNED != 0) && in_data[IN_W-1];
        s1_mag_d  = s1_sign_d ? (~in_data + IN_W'(1)) : in_data;
    end

    int2float_lod #(
        .IN_W (IN_W),
        .LW   (LW)
    ) u_lod (
        .data_i (s1_mag_d),
        .idx_o  (s1_p_d),
        .zero_o (s1_zero_d)
    );

    // Stage 1: register sign, magnitude and leading-one position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
            s1_p_q     <= '0;
            s1_zero_q  <= 1'b1;
        end else if (s1_advance) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= s1_sign_d;
                s1_mag_q  <= s1_mag_d;
                s1_p_q    <= s1_p_d;
                s1_zero_q <= s1_zero_d;
            end
        end
    end

    // Normalise the magnitude into exponent/mantissa, optionally round, then saturate
    always_comb begin
        exp_int = 0;
        man_w   = '0;
        sign_d  = 1'b0;
        exp_d   = '0;
        man_d   = '0;
        sat_d   = 1'b0;
`ifdef INT2FLOAT_RNE_EN
        guard   = 1'b0;
        sticky  = 1'b0;
        man_r   = '0;
`endif
        if (!s1_zero_q) begin
            if (int'(s1_p_q) >= MAN_W) begin
                exp_int = int'(s1_p_q) + 1 - MAN_W;
            end
            man_w = MAN_W'(s1_mag_q >> exp_int);
`ifdef INT2FLOAT_RNE_EN
            if (exp_int > 0) begin
                guard  = |((s1_mag_q >> (exp_int - 1)) & IN_W'(1));
                sticky = |(s1_mag_q & ~({IN_W{1'b1}} << (exp_int - 1)));
                man_r  = {1'b0, man_w};
                if (guard && (sticky || man_w[0])) begin
                    man_r = man_r + (MAN_W+1)'(1);
                end
                // A carry out of the mantissa becomes 100..0 with the exponent bumped
                if (man_r[MAN_W]) begin
                    man_w   = MAN_W'(1) << (MAN_W - 1);
                    exp_int = exp_int + 1;
                end else begin
                    man_w = man_r[MAN_W-1:0];
                end
            end
`endif
            sign_d = s1_sign_q;
            if (exp_int > EMAX) begin
                exp_d = '1;
                man_d = MAN_W'(man_max(MAN_W));
                sat_d = 1'b1;
            end else begin
                exp_d = EXP_W'(exp_int);
                man_d = man_w;
            end
        end
    end

    // Stage 2: hold the packed result stable until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            man_q      <= '0;
            sat_q      <= 1'b0;
        end else if (s2_advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sign_q <= sign_d;
                exp_q  <= exp_d;
                man_q  <= man_d;
                sat_q  <= sat_d;
            end
        end
    end

    // Count delivered saturated results; clear has priority and the count sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else if (sat_clr) begin
            sat_cnt_q <= '0;
        end else if (s2_valid_q && out_ready && sat_q && !(&sat_cnt_q)) begin
            sat_cnt_q <= sat_cnt_q + CNT_W'(1);
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sign  = sign_q;
    assign out_exp   = exp_q;
    assign out_man   = man_q;
    assign out_sat   = sat_q;
    assign sat_cnt   = sat_cnt_q;

endmodule
